// File: rtl/pixel_pkg.sv
// Shared constants for the pixel classifier slice:
// colour codes, counter width and FSM state encodings.
package pixel_pkg;

    localparam int CNT_W = 15;

    localparam logic [1:0] COLOR_R = 2'b00;
    localparam logic [1:0] COLOR_G = 2'b01;
    localparam logic [1:0] COLOR_B = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        EOP   = 2'b10
    } state_t;

endpackage

// File: rtl/dominant_select.sv
// Combinational dominant-colour pick (ties R>G>B) plus a flag
// marking pixels whose brightest channel is below DARK_THRESHOLD.
module dominant_select
    import pixel_pkg::*;
#(
    parameter int PIX_W          = 8,
    parameter int DARK_THRESHOLD = 16
) (
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    output logic [1:0]       color,
    output logic             dark
);

    logic [PIX_W-1:0] mx;

    // Pick the winning channel; its value is also the pixel maximum
    always_comb begin
        color = COLOR_B;
        mx    = b;
        if (r >= g && r >= b) begin
            color = COLOR_R;
            mx    = r;
        end else if (g >= b) begin
            color = COLOR_G;
            mx    = g;
        end
        dark = 32'(mx) < 32'(DARK_THRESHOLD);
    end

endmodule

// File: rtl/pixel_classifier.sv
// Pixel stream classifier feeding the per-colour counting stage.
// Optional dark-pixel rejection is enabled by defining DARK_REJECT_EN.
module pixel_classifier
    import pixel_pkg::*;
#(
    parameter int PIX_W              = 8,
    parameter int PIXELS_PER_PICTURE = 16384,
    parameter int DARK_THRESHOLD     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    output logic             Radd_en,
    output logic             Gadd_en,
    output logic             Badd_en,
    output logic             one_picture,
    output logic [7:0]       pic_count,
    output logic [CNT_W-1:0] pix_idx
);

`ifdef DARK_REJECT_EN
    localparam bit REJECT = 1'b1;
`else
    localparam bit REJECT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_PICTURE - 1);

    state_t     state;
    state_t     state_d;
    logic [1:0] color;
    logic       dark;
    logic       accept;
    logic       count_en;
    logic       ready_d;
    logic       eop_d;

    dominant_select #(
        .PIX_W         (PIX_W),
        .DARK_THRESHOLD(DARK_THRESHOLD)
    ) u_sel (
        .r    (pix_r),
        .g    (pix_g),
        .b    (pix_b),
        .color(color),
        .dark (dark)
    );

    assign accept   = pix_valid & pix_ready;
    assign count_en = accept & ~(REJECT & dark);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_d;
    end

    // Next state: a picture ends on its last accepted pixel
    always_comb begin
        state_d = state;
        unique case (state)
            RUN:     if (accept && pix_idx == LAST_IDX) state_d = DRAIN;
            DRAIN:   state_d = EOP;
            EOP:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        ready_d = (state_d == RUN);
        eop_d   = (state_d == EOP);
    end

    // Registered handshake, framing pulse and colour enables
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ready   <= 1'b0;
            one_picture <= 1'b0;
            Radd_en     <= 1'b0;
            Gadd_en     <= 1'b0;
            Badd_en     <= 1'b0;
        end else begin
            pix_ready   <= ready_d;
            one_picture <= eop_d;
            Radd_en     <= count_en && color == COLOR_R;
            Gadd_en     <= count_en && color == COLOR_G;
            Badd_en     <= count_en && color == COLOR_B;
        end
    end

    // Pixel index within the picture and completed-picture count
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_idx   <= '0;
            pic_count <= '0;
        end else if (state == DRAIN) begin
            pix_idx   <= '0;
            pic_count <= pic_count + 8'd1;
        end else if (accept) begin
            pix_idx   <= pix_idx + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pixel_classifier.sv
// Scoreboard bench for pixel_classifier: a 4-pixel-picture instance
// under directed and random traffic, and a 1-pixel-picture instance for wrap.
module tb_pixel_classifier;

    localparam int PPP = 4;

`ifdef DARK_REJECT_EN
    localparam bit DARK_ON = 1'b1;
`else
    localparam bit DARK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
    logic        Radd_en, Gadd_en, Badd_en, one_picture;
    logic [7:0]  pic_count;
    logic [14:0] pix_idx;

    logic        reset_b = 1'b1;
    logic        valid_b = 1'b0;
    logic        ready_b;
    logic [7:0]  rb_r = 8'd5, rb_g = 8'd9, rb_b = 8'd1;
    logic        Radd_b, Gadd_b, Badd_b, one_b;
    logic [7:0]  pic_b;
    logic [14:0] idx_b;

    pixel_classifier #(.PIX_W(8), .PIXELS_PER_PICTURE(PPP), .DARK_THRESHOLD(16)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .Radd_en(Radd_en), .Gadd_en(Gadd_en), .Badd_en(Badd_en),
        .one_picture(one_picture), .pic_count(pic_count), .pix_idx(pix_idx)
    );

    pixel_classifier #(.PIX_W(8), .PIXELS_PER_PICTURE(1), .DARK_THRESHOLD(16)) dut_b (
        .clk(clk), .reset(reset_b), .pix_valid(valid_b), .pix_ready(ready_b),
        .pix_r(rb_r), .pix_g(rb_g), .pix_b(rb_b),
        .Radd_en(Radd_b), .Gadd_en(Gadd_b), .Badd_en(Badd_b),
        .one_picture(one_b), .pic_count(pic_b), .pix_idx(idx_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int c;
        int code;
    } ev_t;
    ev_t q[$];

    int m_idx = 0;
    int m_pics = 0;
    int rdy_from = 1 << 30;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: colour 0=R 1=G 2=B chosen as the first channel equal to the maximum
    function automatic int ref_color(input int r, input int g, input int b);
        int m;
        m = r;
        if (g > m) m = g;
        if (b > m) m = b;
        if (r == m) return 0;
        if (g == m) return 1;
        return 2;
    endfunction

    function automatic bit ref_dark(input int r, input int g, input int b);
        int m;
        m = r;
        if (g > m) m = g;
        if (b > m) m = b;
        return DARK_ON && (m < 16);
    endfunction

    // One cycle of stimulus, called at a falling edge
    task automatic step(input bit v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        bit exp_rdy;
        pix_valid = v;
        pix_r = r;
        pix_g = g;
        pix_b = b;
        exp_rdy = (cyc >= rdy_from);
        chk("pix_ready", int'(pix_ready), int'(exp_rdy));
        if (v && exp_rdy) begin
            chk("pix_idx", int'(pix_idx), m_idx);
            chk("pic_count", int'(pic_count), m_pics);
            if (!ref_dark(r, g, b))
                q.push_back('{c: cyc + 1, code: ref_color(r, g, b)});
            m_idx++;
            if (m_idx == PPP) begin
                q.push_back('{c: cyc + 2, code: 3});
                m_idx = 0;
                m_pics = (m_pics + 1) % 256;
                rdy_from = cyc + 3;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 8 && !done; t++) begin
            if (cyc >= rdy_from) begin
                step(1'b1, r, g, b);
                done = 1'b1;
            end else begin
                step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic apply_reset();
        pix_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_en", int'({Radd_en, Gadd_en, Badd_en}), 0);
        chk("rst_one_picture", int'(one_picture), 0);
        chk("rst_pix_idx", int'(pix_idx), 0);
        chk("rst_pic_count", int'(pic_count), 0);
        reset = 1'b0;
        m_idx = 0;
        m_pics = 0;
        rdy_from = cyc + 1;
    endtask

    function automatic logic [7:0] rnd_ch();
        case ($urandom_range(0, 3))
            0:       return 8'd90;
            1:       return 8'($urandom_range(0, 20));
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: every enable or framing pulse must match the oldest expectation
    always @(negedge clk) begin
        int n;
        int ev;
        n = int'(Radd_en) + int'(Gadd_en) + int'(Badd_en) + int'(one_picture);
        ev = one_picture ? 3 : (Gadd_en ? 1 : (Badd_en ? 2 : 0));
        if (n > 1) begin
            chk("onehot_outputs", n, 1);
        end else if (n == 1) begin
            if (q.size() == 0) begin
                chk("unexpected_event", ev, -1);
            end else begin
                chk("event_code", ev, q[0].code);
                chk("event_cycle", cyc, q[0].c);
                void'(q.pop_front());
            end
        end
        while (q.size() != 0 && q[0].c <= cyc) begin
            chk("missed_event", n, 1);
            void'(q.pop_front());
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        apply_reset();

        send_pixel(8'd200, 8'd10, 8'd10);
        send_pixel(8'd10, 8'd200, 8'd10);
        send_pixel(8'd10, 8'd10, 8'd200);
        send_pixel(8'd50, 8'd50, 8'd50);

        send_pixel(8'd90, 8'd90, 8'd40);
        send_pixel(8'd30, 8'd90, 8'd90);
        send_pixel(8'd0, 8'd0, 8'd0);
        send_pixel(8'd40, 8'd90, 8'd90);

        send_pixel(8'd15, 8'd3, 8'd3);
        send_pixel(8'd16, 8'd3, 8'd3);
        send_pixel(8'd16, 8'd16, 8'd3);
        send_pixel(8'd3, 8'd3, 8'd15);

        for (int k = 0; k < 4; k++) begin
            send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
            idle(2);
        end

        send_pixel(8'd1, 8'd2, 8'd3);
        send_pixel(8'd3, 8'd2, 8'd1);
        apply_reset();
        for (int k = 0; k < 4; k++)
            send_pixel(8'd7, 8'd70, 8'd7);
        idle(4);
        chk("count_after_reset", int'(pic_count), 1);

        for (int p = 0; p < 30; p++) begin
            for (int k = 0; k < PPP; k++) begin
                if ($urandom_range(0, 3) == 0)
                    idle(int'($urandom_range(1, 2)));
                send_pixel(rnd_ch(), rnd_ch(), rnd_ch());
            end
        end
        idle(5);
        chk("final_pic_count", int'(pic_count), m_pics);
        chk("final_pix_idx", int'(pix_idx), m_idx);
        chk("queue_drained", q.size(), 0);

        begin
            int pulses;
            int ens;
            int others;
            bit prev;
            pulses = 0;
            ens = 0;
            others = 0;
            prev = 1'b0;
            reset_b = 1'b0;
            valid_b = 1'b1;
            for (int k = 0; k < 1200 && pulses < 256; k++) begin
                @(negedge clk);
                ens += int'(Gadd_b);
                others += int'(Radd_b) + int'(Badd_b);
                if (one_b) begin
                    chk("one_picture_width", int'(prev), 0);
                    pulses++;
                end
                prev = one_b;
            end
            valid_b = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                ens += int'(Gadd_b);
                others += int'(Radd_b) + int'(Badd_b);
                pulses += int'(one_b);
            end
            chk("wrap_pulses", pulses, 256);
            chk("wrap_enables", ens, 256);
            chk("wrap_other_enables", others, 0);
            chk("wrap_pic_count", int'(pic_b), 0);
            chk("wrap_ready_idle", int'(ready_b), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
